// File: rtl/wshb_tg_pkg.sv
// wshb_tg_pkg: shared types and constants for the Wishbone traffic generator
package wshb_tg_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_WRITE, ST_GAP, ST_READ, ST_DONE} state_t;
  typedef enum logic [1:0] {MODE_ADDR, MODE_LFSR, MODE_NADDR, MODE_RSVD} mode_t;
  localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam int ERR_W = 16;
  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_POLY : 32'h0);
  endfunction
endpackage

// File: rtl/wshb_tg_lfsr.sv
// wshb_tg_lfsr: 32-bit Galois LFSR pattern source with clear and advance
module wshb_tg_lfsr
  import wshb_tg_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        adv,
  output logic [31:0] value
);
  logic [31:0] value_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) value_q <= LFSR_SEED;
    else if (clr) value_q <= LFSR_SEED;
    else if (adv) value_q <= lfsr_next(value_q);
  assign value = value_q;
endmodule

// File: rtl/wshb_traffic_gen.sv
// wshb_traffic_gen: Wishbone classic master that writes a pattern window, reads it back and checks it
module wshb_traffic_gen
  import wshb_tg_pkg::*;
#(
  parameter int DATA_BYTES = 2,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int NWORDS = 1024,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [1:0]              mode,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    timeout,
  output logic [ERR_W-1:0]        err_count,
  output logic [ADDR_WIDTH-1:0]   first_err_addr,
  output logic [ADDR_WIDTH-1:0]   wb_adr,
  output logic [8*DATA_BYTES-1:0] wb_dat_ms,
  output logic [DATA_BYTES-1:0]   wb_sel,
  output logic                    wb_we,
  output logic                    wb_cyc,
  output logic                    wb_stb,
  input  logic [8*DATA_BYTES-1:0] wb_dat_sm,
  input  logic                    wb_ack,
  input  logic                    wb_err
);
  localparam int DW = 8*DATA_BYTES;
  localparam int CW = $clog2(NWORDS+1);
  localparam int TW = $clog2(TIMEOUT+1);
  state_t state_q, state_d;
  mode_t mode_q, mode_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [TW-1:0] wait_q, wait_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [ADDR_WIDTH-1:0] ferr_q, ferr_d;
  logic tmo_q, tmo_d;
  logic [31:0] lfsr;
  logic lfsr_clr, active, resp, last, err_hit, unused_lfsr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DW-1:0] pat;
  wshb_tg_lfsr u_lfsr (.clk(clk), .reset(reset), .clr(lfsr_clr), .adv(resp), .value(lfsr));
  assign unused_lfsr = ^lfsr;
  assign active = state_q == ST_WRITE || state_q == ST_READ;
  assign addr = BASE_ADDR + ADDR_WIDTH'(idx_q) * ADDR_WIDTH'(DATA_BYTES);
  assign pat = mode_q == MODE_LFSR ? DW'(lfsr) : mode_q == MODE_NADDR ? ~DW'(addr) : DW'(addr);
  assign resp = active && (wb_ack || wb_err);
  assign last = idx_q == CW'(NWORDS-1);
  // err takes precedence over ack, so a simultaneous ack never adds a data compare
  assign err_hit = active && (wb_err || (state_q == ST_READ && wb_ack && wb_dat_sm != pat));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_ADDR;
      idx_q   <= '0;
      wait_q  <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      tmo_q   <= tmo_d;
    end
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    idx_d    = idx_q;
    wait_d   = wait_q;
    err_d    = err_q;
    ferr_d   = ferr_q;
    tmo_d    = tmo_q;
    lfsr_clr = 1'b0;
    if ((state_q == ST_IDLE || state_q == ST_DONE) && start) begin
      state_d  = ST_WRITE;
      mode_d   = mode_t'(mode);
      idx_d    = '0;
      wait_d   = '0;
      err_d    = '0;
      ferr_d   = '0;
      tmo_d    = 1'b0;
      lfsr_clr = 1'b1;
    end else if (state_q == ST_GAP) begin
      state_d  = ST_READ;
      idx_d    = '0;
      wait_d   = '0;
      lfsr_clr = 1'b1;
    end else if (active) begin
      if (resp) begin
        idx_d  = idx_q + CW'(1);
        wait_d = '0;
        if (last) state_d = state_q == ST_WRITE ? ST_GAP : ST_DONE;
      end else if (wait_q == TW'(TIMEOUT)) begin
        tmo_d   = 1'b1;
        state_d = ST_DONE;
      end else begin
        wait_d = wait_q + TW'(1);
      end
      if (err_hit) begin
        err_d  = &err_q ? err_q : err_q + ERR_W'(1);
        ferr_d = err_q == '0 ? addr : ferr_q;
      end
    end
  end
  assign wb_cyc         = active;
  assign wb_stb         = active;
  assign wb_we          = state_q == ST_WRITE;
  assign wb_sel         = active ? '1 : '0;
  assign wb_adr         = active ? addr : '0;
  assign wb_dat_ms      = wb_we ? pat : '0;
  assign busy           = active || state_q == ST_GAP;
  assign done           = state_q == ST_DONE;
  assign pass           = done && err_q == '0 && !tmo_q;
  assign timeout        = tmo_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;
endmodule

// File: doc/wshb_traffic_gen.md
# wshb_traffic_gen

Synthesizable, parametrised Wishbone classic master that writes a selectable data pattern over a contiguous address window, reads it back and checks it. It replaces the hand-written `test` program as stimulus for `wb16_sdram16` and its wider successors, and can also run on the DE1 board as a memory self-test. Data width, window base and size, pattern mode and the ack timeout are all configurable.

## Interface
Parameters:
- DATA_BYTES, 2: bus width in bytes; DW = 8*DATA_BYTES.
- ADDR_WIDTH, 32: byte address width.
- BASE_ADDR, 0: first byte address of the window; must be DATA_BYTES-aligned.
- NWORDS, 1024: words per phase, ≥1; counter width $clog2(NWORDS+1).
- TIMEOUT, 255: maximum wait cycles for ack/err per access, ≥1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle request to begin a run.
- mode  in  2  pattern: 0 ADDR, 1 LFSR, 2 NADDR (inverted address), 3 reserved (treated as ADDR).
- busy  out  1  run in progress.
- done  out  1  run finished; held until the next accepted start.
- pass  out  1  valid when done: no mismatch, no bus error, no timeout.
- timeout  out  1  sticky; an access exceeded TIMEOUT.
- err_count  out  16  read mismatches plus wb_err responses; saturates at 0xFFFF.
- first_err_addr  out  ADDR_WIDTH  byte address of the first error.
- wb_adr  out  ADDR_WIDTH;  wb_dat_ms  out  DW;  wb_sel  out  DATA_BYTES (all ones);  wb_we  out  1;  wb_cyc  out  1;  wb_stb  out  1.
- wb_dat_sm  in  DW;  wb_ack  in  1;  wb_err  in  1.

## Operation
- States: IDLE, WRITE, GAP, READ, DONE.
- IDLE/DONE + start → WRITE. Counters, err_count, first_err_addr, timeout and pattern generator are cleared; done drops. start is ignored in WRITE, GAP and READ.
- WRITE: cyc=stb=we=1, adr=BASE_ADDR+i*DATA_BYTES, dat_ms=pattern(i). On ack or err, i increments and the next address is presented the following cycle with stb held high. After word NWORDS-1 is acknowledged → GAP.
- GAP: one cycle with cyc=stb=0; i and the pattern generator are reset → READ.
- READ: cyc=stb=1, we=0, same address sequence. On ack, wb_dat_sm is compared with pattern(i); a mismatch increments err_count. After the last word → DONE.
- wb_err in either phase counts as a completed access and increments err_count. If ack and err are high in the same cycle, err wins.
- first_err_addr is captured on the first error only.
- Timeout: a wait counter runs while stb is high and clears on each ack/err. When it reaches TIMEOUT without a response: timeout=1, cyc/stb drop, state → DONE.
- DONE: busy=0, done=1, pass = (err_count==0) && !timeout.
- Patterns, taking the low DW bits:
  - ADDR = wb_adr.
  - NADDR = ~wb_adr.
  - LFSR is 32-bit Galois: seed 0xACE1_0001; next = (l>>1) ^ (l[0] ? 0x8020_0003 : 0); advances on each completed access.

## Timing
- Reset values: every output 0, state IDLE.
- Reset asserted mid-run drops cyc/stb immediately (asynchronous).
- start sampled at edge N → cyc/stb/busy high after edge N.
- Zero-wait slave (ack combinational in the cycle stb is high): one word per cycle. A run takes 2*NWORDS+1 cycles from the first stb to the DONE state.
- done, pass and err_count are final on the cycle busy falls.
- Address wrap-around past 2^ADDR_WIDTH is not checked; the integrator keeps the window in range.

## Structure
- Package wshb_tg_pkg holds:
  - state_t and mode_t enums;
  - LFSR_SEED and LFSR_POLY constants;
  - the err_count width (16).
- Sub-module wshb_tg_lfsr: 32-bit register with ports clr and adv and output value. Instantiated once; the top truncates its output to DW.

## Test plan
- With wb16_sdram16 and the sdr model, NWORDS=256, mode 0 → done=1, pass=1, err_count=0, exactly 512 acks, first write at 0x0 with data 0x0000.
- Mode 1 → written words 0x0001, 0x8003, …; readback identical; pass=1.
- Behavioural slave that flips bit 0 on the read of word 5 (mode 2) → err_count=1, first_err_addr=BASE_ADDR+10, pass=0.
- Slave that never acks, TIMEOUT=15 → cyc low 16 cycles after stb rises, timeout=1, pass=0, err_count=0.
- Slave that returns wb_err on write word 3, then start pulsed during READ → err_count=1, start ignored, run completes; a second start clears all status.
- reset asserted at write word 100 → all outputs 0 in the same cycle; a later start runs cleanly to pass=1.
